byte_bank_ctrl: RTL

Write sequencer and two-port arbiter for a bank of `NUM_BYTES` level-sensitive byte latches: byte-wide storage cells that store while their store line is high and are transparent during that time. Two requesters share the bank through valid/ready handshakes. The controller serialises their writes and sequences each one as setup → store pulse → hold, so latch data is stable around every store window. It also provides a registered read port over the bank outputs.

---
 rtl/byte_bank_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/byte_bank_ctrl.sv
// Two-requester write sequencer for a bank of byte latches. Each write runs
// setup -> store pulse -> hold so latch D is stable around the store window.
module byte_bank_lane #(
  parameter int ADDR_W = 2,
  parameter int IDX    = 0
) (
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [7:0]        i_q,
  output logic              o_hit,
  output logic [7:0]        o_rd
);
  assign o_hit = (i_wr_addr == ADDR_W'(IDX));
  assign o_rd  = (i_rd_addr == ADDR_W'(IDX)) ? i_q : 8'h00;
endmodule

module byte_bank_ctrl #(
  parameter int NUM_BYTES = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [7:0]             req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [7:0]             req1_data,
  output logic                   req1_ready,
  output logic [7:0]             bank_data,
  output logic [NUM_BYTES-1:0]   bank_store,
  input  logic [8*NUM_BYTES-1:0] bank_q,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [7:0]             rd_data,
  output logic                   busy,
  output logic                   grant_id,
  output logic                   wr_err
);
  typedef enum logic [1:0] {IDLE, SETUP, STORE, HOLD} state_t;

  state_t                       r_state;
  logic                         r_last;
  logic                         r_gid;
  logic [ADDR_W-1:0]            r_addr;
  logic [7:0]                   r_data;
  logic [7:0]                   r_rd;
  logic [NUM_BYTES-1:0]         r_store;
  logic                         r_err;

  logic                         w_idle;
  logic                         w_pick1;
  logic                         w_acc;
  logic                         w_oob;
  logic [NUM_BYTES-1:0]         w_hit;
  logic [NUM_BYTES-1:0][7:0]    w_rd_lane;
  logic [7:0]                   w_rd;

  assign w_idle  = (r_state == IDLE) && !reset;
  // On contention the requester not granted last wins.
  assign w_pick1 = req1_valid && (!req0_valid || !r_last);
  assign w_acc   = w_idle && (req0_valid || req1_valid);
  assign w_oob   = 32'(r_addr) >= 32'(NUM_BYTES);

  assign req0_ready = w_idle && req0_valid && !w_pick1;
  assign req1_ready = w_idle && w_pick1;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    byte_bank_lane #(.ADDR_W(ADDR_W), .IDX(g)) u_lane (
      .i_wr_addr (r_addr),
      .i_rd_addr (rd_addr),
      .i_q       (bank_q[8*g +: 8]),
      .o_hit     (w_hit[g]),
      .o_rd      (w_rd_lane[g])
    );
  end

  always_comb begin
    w_rd = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) w_rd = w_rd | w_rd_lane[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gid   <= 1'b0;
      r_addr  <= '0;
      r_data  <= 8'h00;
      r_store <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= SETUP;
          r_gid   <= w_pick1;
          r_last  <= w_pick1;
          r_addr  <= w_pick1 ? req1_addr : req0_addr;
          r_data  <= w_pick1 ? req1_data : req0_data;
        end
        SETUP: begin
          r_state <= STORE;
          r_store <= w_hit;
          r_err   <= w_oob;
        end
        STORE: begin
          r_state <= HOLD;
          r_store <= '0;
          r_err   <= 1'b0;
        end
        HOLD:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd <= 8'h00;
    else       r_rd <= w_rd;
  end

  assign bank_data  = r_data;
  assign bank_store = r_store;
  assign rd_data    = r_rd;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_gid;
  assign wr_err     = r_err;
endmodule
